rbz_spi_loader: RTL

SPI sequencer that feeds the raybox-zero core's two serial configuration ports: the vector port (player position/facing/plane) and the register port (colours, modes, texture options). It accepts whole-word load requests from two on-chip requesters, arbitrates between them round-robin, and serializes each accepted word MSB-first. It drives the core's `vec_csb/sclk/mosi` and `reg_csb/sclk/mosi` pins, so firmware no longer bit-bangs them over LA lines. It sits inside the wrapper between the request sources (Wishbone shim, LA bridge) and `top_ew_algofoogle`.

---
 rtl/rbz_loader_pkg.sv | 18 +
 rtl/rbz_sclk_div.sv | 36 +++
 rtl/rbz_spi_loader.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/rbz_loader_pkg.sv
// Shared types and widths for the raybox-zero SPI loader.
package rbz_loader_pkg;

  localparam int LEN_W = 7;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  typedef enum logic {
    TGT_VEC = 1'b0,
    TGT_REG = 1'b1
  } tgt_t;

endpackage

// File: rtl/rbz_sclk_div.sv
// SCLK phase divider: DIV-cycle counter whose wraps alternate between
// "rise" and "fall" ticks. Clearing restarts at the low half-period.
module rbz_sclk_div #(
  parameter int DIV = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clr,
  output logic o_rise,
  output logic o_fall
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;
  logic          half;
  logic          wrap;

  assign wrap   = (cnt == CW'(DIV - 1));
  assign o_rise = wrap & ~half;
  assign o_fall = wrap & half;

  // Count DIV cycles per half-period; half tracks which edge comes next.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr) begin
      cnt  <= '0;
      half <= 1'b0;
    end else if (wrap) begin
      cnt  <= '0;
      half <= ~half;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rbz_spi_loader.sv
// Round-robin SPI loader for the raybox-zero vector and register ports.
// Optional macro RBZ_LOADER_VSYNC_GATE_EN adds i_vsync; vector requests
// are then only accepted while it is high.
module rbz_spi_loader
  import rbz_loader_pkg::*;
#(
  parameter int DIV  = 2,
  parameter int MAXW = 80
) (
  input  logic             i_clk,
  input  logic             i_reset,
`ifdef RBZ_LOADER_VSYNC_GATE_EN
  input  logic             i_vsync,
`endif
  input  logic             i_vec_valid,
  output logic             o_vec_ready,
  input  logic [MAXW-1:0]  i_vec_data,
  input  logic [LEN_W-1:0] i_vec_len,
  input  logic             i_reg_valid,
  output logic             o_reg_ready,
  input  logic [MAXW-1:0]  i_reg_data,
  input  logic [LEN_W-1:0] i_reg_len,
  output logic             o_vec_csb,
  output logic             o_vec_sclk,
  output logic             o_vec_mosi,
  output logic             o_reg_csb,
  output logic             o_reg_sclk,
  output logic             o_reg_mosi,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_done_tgt
);

  state_t           state;
  tgt_t             tgt, last;
  logic             csb, sclk, mosi;
  logic [MAXW-1:0]  shreg;
  logic [LEN_W-1:0] bits_left;

  logic             vec_ok, reg_ok, pick_reg, arb_en, load;
  logic             rise, fall, tick;
  logic [LEN_W-1:0] len_in, len_eff;
  logic [MAXW-1:0]  data_in, ljust;

  rbz_sclk_div #(.DIV(DIV)) u_div (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (load),
    .o_rise  (rise),
    .o_fall  (fall)
  );

  assign tick = rise | fall;

  // Request qualification, arbitration and payload left-justification.
  always_comb begin
`ifdef RBZ_LOADER_VSYNC_GATE_EN
    vec_ok = i_vec_valid & i_vsync;
`else
    vec_ok = i_vec_valid;
`endif
    reg_ok   = i_reg_valid;
    pick_reg = reg_ok && (!vec_ok || last == TGT_VEC);
    // Arbitrate in IDLE, or on the last GAP cycle so ready lands right as busy drops.
    arb_en   = ((state == IDLE) && !o_vec_ready && !o_reg_ready) ||
               ((state == GAP) && tick);
    load     = (state == IDLE) && (o_vec_ready || o_reg_ready);
    len_in   = (tgt == TGT_REG) ? i_reg_len : i_vec_len;
    data_in  = (tgt == TGT_REG) ? i_reg_data : i_vec_data;
    len_eff  = (len_in > LEN_W'(MAXW)) ? LEN_W'(MAXW) : len_in;
    ljust    = data_in << (LEN_W'(MAXW) - len_eff);
  end

  // Shared pins are steered to the selected port; tgt only changes while idle.
  assign o_vec_csb  = csb | (tgt == TGT_REG);
  assign o_vec_sclk = sclk & (tgt == TGT_VEC);
  assign o_vec_mosi = mosi & (tgt == TGT_VEC);
  assign o_reg_csb  = csb | (tgt == TGT_VEC);
  assign o_reg_sclk = sclk & (tgt == TGT_REG);
  assign o_reg_mosi = mosi & (tgt == TGT_REG);

  // Sequencer: accept/latch, shift MSB-first, hold, then inter-word gap.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= IDLE;
      tgt         <= TGT_VEC;
      last        <= TGT_REG;
      csb         <= 1'b1;
      sclk        <= 1'b0;
      mosi        <= 1'b0;
      shreg       <= '0;
      bits_left   <= '0;
      o_vec_ready <= 1'b0;
      o_reg_ready <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_done_tgt  <= 1'b0;
    end else begin
      o_done      <= 1'b0;
      o_vec_ready <= 1'b0;
      o_reg_ready <= 1'b0;
      if (arb_en && (vec_ok || reg_ok)) begin
        if (pick_reg) begin
          o_reg_ready <= 1'b1;
          tgt         <= TGT_REG;
          last        <= TGT_REG;
        end else begin
          o_vec_ready <= 1'b1;
          tgt         <= TGT_VEC;
          last        <= TGT_VEC;
        end
      end
      case (state)
        IDLE: if (load) begin
          if (len_eff == '0) begin
            o_done     <= 1'b1;
            o_done_tgt <= tgt;
          end else begin
            state     <= SHIFT;
            o_busy    <= 1'b1;
            csb       <= 1'b0;
            mosi      <= ljust[MAXW-1];
            shreg     <= ljust << 1;
            bits_left <= len_eff;
          end
        end
        SHIFT: begin
          if (rise) begin
            sclk <= 1'b1;
          end else if (fall) begin
            sclk <= 1'b0;
            if (bits_left == LEN_W'(1)) begin
              state <= HOLD;
              mosi  <= 1'b0;
            end else begin
              mosi      <= shreg[MAXW-1];
              shreg     <= shreg << 1;
              bits_left <= bits_left - 1'b1;
            end
          end
        end
        HOLD: if (tick) begin
          csb        <= 1'b1;
          o_done     <= 1'b1;
          o_done_tgt <= tgt;
          state      <= GAP;
        end
        GAP: if (tick) begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
